// File: rtl/integral_image_decoder_if.sv
// Register bus for integral_image_decoder.
//   cs_n     : chip select, active low
//   addr     : register address
//   set_data : write data
//   write_b  : write strobe, active low (qualified by cs_n)
//   get_data : read data, registered one cycle after addr
// master drives the bus (host/bench), slave is the decoder.
interface integral_image_decoder_if #(
  parameter int unsigned PARSIZE = 16
);
  logic               cs_n;
  logic [2:0]         addr;
  logic [PARSIZE-1:0] set_data;
  logic [PARSIZE-1:0] get_data;
  logic               write_b;

  modport master (
    output cs_n,
    output addr,
    output set_data,
    output write_b,
    input  get_data
  );

  modport slave (
    input  cs_n,
    input  addr,
    input  set_data,
    input  write_b,
    output get_data
  );
endinterface

// File: rtl/integral_image_decoder.sv
// Integral image decoder: rebuilds raster pixels from a stream of integral-image words.
//   Y(r,c) = II(r,c) - II(r,c-1) - II(r-1,c) + II(r-1,c-1), out-of-frame terms are 0.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   II_i                  : integral word, raster order
//   frame_valid_i         : input frame active
//   data_valid_i          : II_i valid this cycle
//   regs                  : register bus (0 mode, 1 status, 3 width, 4 height)
//   Y_o                   : reconstructed pixel, holds when data_valid_o=0
//   frame_valid_o         : frame_valid_i delayed by two cycles
//   data_valid_o          : Y_o valid, two cycles after the accepting cycle
// Status: bit0 busy, bit1 clamp, bit2 extra pixel, bit3 short frame (1-3 sticky,
// cleared by any write to addr 1).
// Build option: define IIDEC_CLAMP_EN to saturate out-of-range differences to
// [0, 2^PIXSIZE-1] and flag them in status bit1; otherwise Y_o is the low bits.
module integral_image_decoder #(
  parameter int unsigned PIXSIZE    = 8,
  parameter int unsigned IIWORDSIZE = 32,
  parameter int unsigned PARSIZE    = 16,
  parameter int unsigned COL_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IIWORDSIZE-1:0] II_i,
  input  logic                  frame_valid_i,
  input  logic                  data_valid_i,
  integral_image_decoder_if.slave regs,
  output logic [PIXSIZE-1:0]    Y_o,
  output logic                  frame_valid_o,
  output logic                  data_valid_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q;
  logic [PARSIZE-1:0]   mode_q, width_q, height_q;
  logic [PARSIZE-1:0]   act_w_q, act_h_q;
  logic [PARSIZE-1:0]   col_q, row_q;
  logic                 sts_clamp_q, sts_extra_q, sts_short_q;
  logic [PARSIZE-1:0]   get_data_q;

  logic [IIWORDSIZE-1:0] mem [2**COL_W];
  logic [IIWORDSIZE-1:0] up_q;
  logic [IIWORDSIZE-1:0] prev_ii_q;
  logic                  s1_valid_q, s1_row0_q;
  logic [IIWORDSIZE-1:0] s1_cur_q, s1_left_q, s1_upleft_q;
  logic                  fv_d1_q;

  logic                 reg_we, start, accept, busy;
  logic [PARSIZE-1:0]   cur_w, cur_h;
  logic                 col_last, row_last, frame_last;
  logic                 col0, row0;
  logic [COL_W-1:0]     col_addr;
  logic [PARSIZE-1:0]   rd_data;
  logic [PARSIZE-1:0]   status_word;
  logic [IIWORDSIZE-1:0] up_term, diff;
  logic [PIXSIZE-1:0]   y_next;
  logic                 clamp_hit;

  assign reg_we = !regs.cs_n && !regs.write_b;
  assign busy   = (state_q != StIdle);

  // Geometry is sampled from the registers only at frame start.
  assign cur_w = (state_q == StIdle) ? width_q  : act_w_q;
  assign cur_h = (state_q == StIdle) ? height_q : act_h_q;

  assign col_last   = (col_q == cur_w - PARSIZE'(1));
  assign row_last   = (row_q == cur_h - PARSIZE'(1));
  assign frame_last = col_last && row_last;
  assign col0       = (col_q == '0);
  assign row0       = (row_q == '0);
  assign col_addr   = col_q[COL_W-1:0];

  assign start  = (state_q == StIdle) && frame_valid_i && data_valid_i &&
                  (width_q != '0) && (height_q != '0);
  assign accept = start || ((state_q == StRun) && frame_valid_i && data_valid_i);

  assign status_word = {{(PARSIZE-4){1'b0}}, sts_short_q, sts_extra_q, sts_clamp_q, busy};

  always_comb begin
    rd_data = '0;
    case (regs.addr)
      3'd0:    rd_data = mode_q;
      3'd1:    rd_data = status_word;
      3'd3:    rd_data = width_q;
      3'd4:    rd_data = height_q;
      default: rd_data = '0;
    endcase
  end

  assign regs.get_data = get_data_q;

  // FSM, frame counters and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      act_w_q     <= '0;
      act_h_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      width_q     <= '0;
      height_q    <= '0;
      sts_clamp_q <= 1'b0;
      sts_extra_q <= 1'b0;
      sts_short_q <= 1'b0;
      get_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            act_w_q <= width_q;
            act_h_q <= height_q;
            state_q <= frame_last ? StDrain : StRun;
          end
        end
        StRun: begin
          if (!frame_valid_i) begin
            state_q <= StIdle;
          end else if (accept && frame_last) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!frame_valid_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // An aborted frame drops the partial line: the next frame restarts at row 0.
      if ((state_q == StRun) && !frame_valid_i) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + PARSIZE'(1);
        end else begin
          col_q <= col_q + PARSIZE'(1);
        end
      end

      if (reg_we) begin
        case (regs.addr)
          3'd0: mode_q   <= regs.set_data;
          3'd3: width_q  <= regs.set_data;
          3'd4: height_q <= regs.set_data;
          default: ;
        endcase
      end

      // Clear first so an event in the same cycle still lands.
      if (reg_we && (regs.addr == 3'd1)) begin
        sts_clamp_q <= 1'b0;
        sts_extra_q <= 1'b0;
        sts_short_q <= 1'b0;
      end
      if ((state_q == StRun) && !frame_valid_i) sts_short_q <= 1'b1;
      if ((state_q == StDrain) && frame_valid_i && data_valid_i) sts_extra_q <= 1'b1;
      if (s1_valid_q && clamp_hit) sts_clamp_q <= 1'b1;

      get_data_q <= rd_data;
    end
  end

  // Row memory is not reset; row-0 pixels never use what it returns.
  always_ff @(posedge clk) begin
    if (accept) mem[col_addr] <= II_i;
  end

  // Stage 1 captures the pixel and its left / upper-left neighbours; up_q is the
  // one-cycle memory read of the same column from the previous row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q        <= '0;
      prev_ii_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_row0_q   <= 1'b0;
      s1_cur_q    <= '0;
      s1_left_q   <= '0;
      s1_upleft_q <= '0;
      fv_d1_q     <= 1'b0;
      frame_valid_o <= 1'b0;
      data_valid_o  <= 1'b0;
      Y_o           <= '0;
    end else begin
      if (accept && !row0) up_q <= mem[col_addr];
      if (accept) begin
        prev_ii_q   <= II_i;
        s1_cur_q    <= II_i;
        s1_left_q   <= col0 ? '0 : prev_ii_q;
        // up_q still holds the previous column's upper value here.
        s1_upleft_q <= (col0 || row0) ? '0 : up_q;
        s1_row0_q   <= row0;
      end
      s1_valid_q    <= accept;
      fv_d1_q       <= frame_valid_i;
      frame_valid_o <= fv_d1_q;
      data_valid_o  <= s1_valid_q;
      if (s1_valid_q) Y_o <= y_next;
    end
  end

  assign up_term = s1_row0_q ? '0 : up_q;

`ifdef IIDEC_CLAMP_EN
  localparam logic [IIWORDSIZE-1:0] PixMax = {{(IIWORDSIZE-PIXSIZE){1'b0}}, {PIXSIZE{1'b1}}};

  always_comb begin
    diff      = s1_cur_q - s1_left_q - up_term + s1_upleft_q;
    y_next    = diff[PIXSIZE-1:0];
    clamp_hit = 1'b0;
    if (diff[IIWORDSIZE-1]) begin
      y_next    = '0;
      clamp_hit = 1'b1;
    end else if (diff > PixMax) begin
      y_next    = '1;
      clamp_hit = 1'b1;
    end
  end
`else
  logic unused_diff_hi;

  always_comb begin
    diff      = s1_cur_q - s1_left_q - up_term + s1_upleft_q;
    y_next    = diff[PIXSIZE-1:0];
    clamp_hit = 1'b0;
  end

  assign unused_diff_hi = ^diff[IIWORDSIZE-1:PIXSIZE];
`endif

endmodule

// File: tb/tb_integral_image_decoder.sv
module tb_integral_image_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ii = '0;
  logic        fv = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  y_o;
  logic        fv_o, dv_o;

  integral_image_decoder_if #(.PARSIZE(16)) bus ();

  integral_image_decoder #(
    .PIXSIZE(8), .IIWORDSIZE(32), .PARSIZE(16), .COL_W(11)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .II_i          (ii),
    .frame_valid_i (fv),
    .data_valid_i  (dv),
    .regs          (bus),
    .Y_o           (y_o),
    .frame_valid_o (fv_o),
    .data_valid_o  (dv_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int first_in = -1;
  int fvo_rise = -1;
  logic [7:0] out_q[$];
  int         out_cyc_q[$];

  always @(negedge clk) begin
    if (dv_o) begin
      out_q.push_back(y_o);
      out_cyc_q.push_back(cyc);
    end
    if (fv_o && fvo_rise < 0) fvo_rise = cyc;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_test();
    out_q.delete();
    out_cyc_q.delete();
    first_in = -1;
    fvo_rise = -1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.write_b = 1'b0; bus.addr = a; bus.set_data = d;
    @(posedge clk); #1;
    bus.cs_n = 1'b1; bus.write_b = 1'b1;
  endtask

  task automatic reg_read(input logic [2:0] a, output int d);
    @(posedge clk); #1;
    bus.addr = a;
    @(posedge clk); #1;
    d = int'(bus.get_data);
  endtask

  task automatic send(input logic [31:0] v);
    @(posedge clk); #1;
    fv = 1'b1; dv = 1'b1; ii = v;
    if (first_in < 0) first_in = cyc;
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    dv = 1'b0;
    @(posedge clk); #1;
    fv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // II(r,c) = (r+1)*(c+1)*scale decodes to scale at every pixel.
  task automatic feed_product(input int w, input int npix, input int scale);
    for (int i = 0; i < npix; i++) send(32'((i / w + 1) * (i % w + 1) * scale));
  endtask

  task automatic check_outputs(input string tag, input int n, input int expv);
    check_eq({tag, "_count"}, out_q.size(), n);
    for (int i = 0; i < out_q.size() && i < n; i++) check_eq({tag, "_y"}, out_q[i], expv);
  endtask

  int rd;
  int seq_ii[6] = '{10, 30, 60, 50, 120, 210};
  int seq_y[6]  = '{10, 20, 30, 40, 50, 60};

  initial begin
    bus.cs_n = 1'b1; bus.write_b = 1'b1; bus.addr = '0; bus.set_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_y", y_o, 0);
    check_eq("rst_dv", dv_o, 0);
    check_eq("rst_fv", fv_o, 0);
    check_eq("rst_get", bus.get_data, 0);
    rst_n = 1'b1;
    reg_read(3'd1, rd); check_eq("rst_status", rd, 0);
    reg_read(3'd3, rd); check_eq("rst_width", rd, 0);

    // Register port
    reg_write(3'd3, 16'd4);
    reg_write(3'd4, 16'd3);
    reg_write(3'd2, 16'h55);
    reg_write(3'd0, 16'h1234);
    reg_read(3'd3, rd); check_eq("width", rd, 4);
    reg_read(3'd4, rd); check_eq("height", rd, 3);
    reg_read(3'd2, rd); check_eq("reserved", rd, 0);
    reg_read(3'd6, rd); check_eq("unmapped", rd, 0);
    reg_read(3'd0, rd); check_eq("mode", rd, 16'h1234);

    // 4x3 product frame
    start_test();
    feed_product(4, 12, 1);
    end_frame();
    check_outputs("prod", 12, 1);
    if (out_cyc_q.size() > 0) check_eq("latency", out_cyc_q[0] - first_in, 2);
    else check_eq("latency_none", 0, 1);
    check_eq("fvo_delay", fvo_rise - first_in, 2);
    reg_read(3'd1, rd); check_eq("prod_status", rd, 0);

    // 3x2 known pixels, with input bubbles
    reg_write(3'd3, 16'd3);
    reg_write(3'd4, 16'd2);
    start_test();
    for (int i = 0; i < 6; i++) begin
      send(32'(seq_ii[i]));
      @(posedge clk); #1;
      dv = 1'b0;
    end
    end_frame();
    check_eq("seq_count", out_q.size(), 6);
    for (int i = 0; i < 6 && i < out_q.size(); i++) check_eq("seq_y", out_q[i], seq_y[i]);

    // Short frame then clean restart
    reg_write(3'd3, 16'd4);
    reg_write(3'd4, 16'd3);
    start_test();
    feed_product(4, 6, 1);
    end_frame();
    check_outputs("short", 6, 1);
    reg_read(3'd1, rd); check_eq("short_status", rd, 8);
    reg_write(3'd1, 16'd0);
    start_test();
    feed_product(4, 12, 3);
    end_frame();
    check_outputs("restart", 12, 3);
    reg_read(3'd1, rd); check_eq("restart_status", rd, 0);

    // Extra pixels in drain
    start_test();
    feed_product(4, 12, 1);
    send(32'd999);
    send(32'd777);
    end_frame();
    check_outputs("extra", 12, 1);
    reg_read(3'd1, rd); check_eq("extra_status", rd, 4);
    reg_write(3'd1, 16'd0);
    reg_read(3'd1, rd); check_eq("extra_clear", rd, 0);

    // Clamp behaviour
    reg_write(3'd3, 16'd2);
    reg_write(3'd4, 16'd1);
    start_test();
    send(32'd300);
    send(32'd310);
    end_frame();
    check_eq("clamp_count", out_q.size(), 2);
`ifdef IIDEC_CLAMP_EN
    if (out_q.size() == 2) begin
      check_eq("clamp_y0", out_q[0], 255);
      check_eq("clamp_y1", out_q[1], 10);
    end
    reg_read(3'd1, rd); check_eq("clamp_status", rd, 2);
`else
    if (out_q.size() == 2) begin
      check_eq("wrap_y0", out_q[0], 44);
      check_eq("wrap_y1", out_q[1], 10);
    end
    reg_read(3'd1, rd); check_eq("wrap_status", rd, 0);
`endif
    reg_write(3'd1, 16'd0);

    // Reset in mid-frame
    reg_write(3'd3, 16'd4);
    reg_write(3'd4, 16'd3);
    start_test();
    feed_product(4, 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_y", y_o, 0);
    check_eq("midrst_dv", dv_o, 0);
    check_eq("midrst_fv", fv_o, 0);
    check_eq("midrst_get", bus.get_data, 0);
    @(posedge clk); #1;
    check_eq("midrst_dv_hold", dv_o, 0);
    rst_n = 1'b1;
    start_test();
    for (int i = 0; i < 4; i++) send(32'(i + 7));
    end_frame();
    check_eq("postrst_count", out_q.size(), 0);
    reg_read(3'd1, rd); check_eq("postrst_status", rd, 0);
    reg_read(3'd3, rd); check_eq("postrst_width", rd, 0);
    reg_write(3'd3, 16'd4);
    reg_write(3'd4, 16'd3);
    start_test();
    feed_product(4, 12, 2);
    end_frame();
    check_outputs("postrst_frame", 12, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/integral_image_decoder.md
INTEGRAL_IMAGE_DECODER -- requirements
Module: integral_image_decoder

Interface
REQ-001 The module SHALL use parameter PIXSIZE, default 8, as the output pixel width.
REQ-002 The module SHALL use parameter IIWORDSIZE, default 32, as the integral word width.
REQ-003 The module SHALL use parameter PARSIZE, default 16, as the register width.
REQ-004 The module SHALL use parameter COL_W, default 11, as the row-memory address width (max width 2^COL_W).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port II_i, input, IIWORDSIZE bits: the integral pixel, raster order.
REQ-008 The module SHALL have port frame_valid_i, input, 1 bit: input frame active.
REQ-009 The module SHALL have port data_valid_i, input, 1 bit: II_i valid this cycle.
REQ-010 The module SHALL have ports cs_n (input, 1 bit), addr (input, 3 bits), set_data (input, PARSIZE bits), get_data (output, PARSIZE bits) and write_b (input, 1 bit): the register port.
REQ-011 The module SHALL have port Y_o, output, PIXSIZE bits: the reconstructed pixel.
REQ-012 The module SHALL have ports frame_valid_o and data_valid_o, output, 1 bit each: the output qualifiers.

Function
REQ-013 Registers SHALL be written when cs_n=0 and write_b=0: addr 0 mode, 1 status, 3 width, 4 height; addr 2 is reserved and writes to it are ignored.
REQ-014 get_data SHALL present the register selected by addr one cycle later; unmapped addresses SHALL read 0.
REQ-015 The status register SHALL hold: bit0 busy (read-only, state != IDLE), bit1 clamp event, bit2 extra-pixel, bit3 short-frame; bits 1-3 are sticky, and any write to addr 1 SHALL clear them.
REQ-016 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-017 IDLE->RUN SHALL occur on the first cycle with frame_valid_i=1 and data_valid_i=1, provided width!=0 and height!=0; that pixel is column 0, row 0.
REQ-018 RUN->DRAIN SHALL occur after the pixel at column width-1, row height-1 is accepted.
REQ-019 DRAIN SHALL ignore data_valid_i, setting status bit2 on each such pixel, and SHALL return to IDLE when frame_valid_i=0.
REQ-020 If frame_valid_i=0 in RUN, the FSM SHALL go to IDLE, set status bit3, reset the counters, and discard the partial line.
REQ-021 The column counter SHALL wrap at width-1 and increment the row counter; the row counter SHALL wrap at height-1.
REQ-022 A row memory of 2^COL_W words SHALL store each accepted II_i at its column address, and the same column SHALL be read for the next row (one-cycle read latency).
REQ-023 Y SHALL be computed as II(r,c) - II(r,c-1) - II(r-1,c) + II(r-1,c-1), modulo 2^IIWORDSIZE.
REQ-024 Terms with r-1<0 or c-1<0 SHALL be taken as 0.
REQ-025 Latency SHALL be fixed: Y_o/data_valid_o SHALL appear exactly 2 cycles after the accepting cycle.
REQ-026 frame_valid_o SHALL equal frame_valid_i delayed by 2 cycles.
REQ-027 data_valid_o SHALL be 1 only for pixels accepted in RUN.
REQ-028 Y_o SHALL hold its last value when data_valid_o=0.
REQ-029 Register writes to width or height while busy SHALL take effect only at the next IDLE->RUN.

Reset
REQ-030 While rst_n=0, the module SHALL force Y_o=0, data_valid_o=0, frame_valid_o=0, get_data=0, all registers 0, counters 0, pipeline 0, and FSM=IDLE.
REQ-031 Reset asserted mid-frame SHALL abort immediately; after release the module SHALL wait in IDLE for a new frame_valid_i/data_valid_i start.
REQ-032 Row memory contents SHALL NOT be reset; row 0 SHALL never read the memory.

Configuration
REQ-033 With IIDEC_CLAMP_EN defined, a difference outside [0, 2^PIXSIZE-1] (signed interpretation) SHALL clamp to 0 or 2^PIXSIZE-1 and set status bit1.
REQ-034 Without IIDEC_CLAMP_EN, Y_o SHALL be the low PIXSIZE bits of the difference, and status bit1 SHALL read 0.

Verification
REQ-035 A bench SHALL cover: width=4, height=3, II_i(r,c)=(r+1)*(c+1) -> 12 outputs, all Y_o=1, first data_valid_o 2 cycles after first input.
REQ-036 A bench SHALL cover: width=3, height=2, pixels 10,20,30,40,50,60 fed as integral (10,30,60,50,120,210) -> Y_o sequence 10,20,30,40,50,60.
REQ-037 A bench SHALL cover: a 4x3 frame with frame_valid_i dropped after 6 pixels -> 6 outputs, status=0x8, FSM IDLE, and the next frame decodes correctly from row 0.
REQ-038 A bench SHALL cover: a 4x3 frame followed by 2 extra data_valid_i pulses -> 12 outputs only, status bit2=1; after a write to addr 1, status reads 0.
REQ-039 A bench SHALL cover, with IIDEC_CLAMP_EN: width=2, height=1, II_i=300,310 -> Y_o 255,10 and status bit1=1; without it -> Y_o 44,10.
REQ-040 A bench SHALL cover: rst_n pulsed low at pixel 5 of a 4x3 frame -> all outputs 0 within the reset, no further data_valid_o until a new frame start.
